time_keeper: RTL
================

# time_keeper

Running time-of-day core of the watch controller, directly downstream of the time-setting stage. Takes the four BCD digits produced by the time-setting stage (h1, h0, m1, m0) and loads them on a load pulse. From then on it counts seconds, minutes and hours in 24-hour format from a prescaled system clock. It drives the display and alarm stages with six BCD digits and single-cycle event pulses.

## Interface
Parameters:
- TICKS_PER_SEC, default 50_000_000 — clk cycles per second; must be ≥ 2; benches use 4.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- load  in  1  synchronous request to load set_* digits.
- set_h1, set_h0, set_m1, set_m0  in  4 each  BCD time from the time-setting stage.
- run  in  1  1 = time advances; 0 = time and prescaler freeze.
- h1, h0, m1, m0, s1, s0  out  4 each  current time, BCD, registered.
- sec_tick  out  1  one-cycle pulse when seconds advance.
- min_roll  out  1  one-cycle pulse when seconds wrap 59→00.
- day_roll  out  1  one-cycle pulse when time wraps 23:59:59→00:00:00.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- Reset (reset=0, asynchronous): all digits 0, prescaler 0, all pulses 0. Takes effect immediately, including mid-count or mid-load.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 while run=1 and no load.
  - At terminal count it returns to 0 and generates an advance.
  - Holds its value while run=0.
- Advance (seconds increment):
  - s0 counts 0..9; a carry increments s1.
  - s1 counts 0..5; a carry increments m0 and pulses min_roll.
  - m0 counts 0..9 and m1 counts 0..5 in the same way; the m1 carry increments the hour.
  - Hours: h0 counts 0..9 with carry into h1. Special case: at h1=2, h0=3, a carry wraps hours to 00 and pulses day_roll.
- Load validation. A load is valid iff all of:
  - set_h1 ≤ 2;
  - set_h1 ≠ 2 or set_h0 ≤ 3;
  - set_h0 ≤ 9;
  - set_m1 ≤ 5;
  - set_m0 ≤ 9.
- Valid load: h1/h0/m1/m0 take the set_* values; s1, s0 and the prescaler clear to 0.
- Invalid load: all time state and the prescaler are unchanged; load_err pulses.
- Load is accepted regardless of run.
- Priority: reset > load > advance. An advance coinciding with load is discarded; no sec_tick is issued.
- load held high for N cycles is evaluated every cycle. The prescaler stays at 0 throughout, so time does not advance.
- Pulses: min_roll and day_roll coincide with the sec_tick that caused them. day_roll always implies min_roll.

## Timing
- Prescaler reaching TICKS_PER_SEC-1 at edge k → at edge k+1, digits show the advanced value and sec_tick is high for exactly that cycle.
- Load sampled at edge k → new digits or load_err visible after edge k; latency 1 cycle.
- After a valid load, the first sec_tick occurs exactly TICKS_PER_SEC cycles later, given continuous run=1.
- With run=1 continuously, sec_tick period is exactly TICKS_PER_SEC cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- reset release is synchronous-safe: the first count occurs on the edge after deassertion.

## Structure
- Shared package watch_pkg:
  - BCD digit typedef (4-bit);
  - constants for digit limits: SEC_TENS_MAX=5, UNITS_MAX=9, HOUR_TENS_MAX=2, HOUR_UNITS_MAX_AT_20=3.
- The time-setting stage and the display stage use the same package.
- One sub-module, bcd_digit_counter:
  - parameterised maximum;
  - inputs: inc, clr, load, load value;
  - output: carry when at max and inc.
- Six instances of bcd_digit_counter. The hour wrap at 23 is handled in time_keeper by forcing clr on both hour digits.
- Prescaler and load validation live in time_keeper.

## Test plan
- Reset and first second: reset low 3 cycles, release, run=1, TICKS_PER_SEC=4 → all digits 0 for cycles 1-3 after release; sec_tick with s0=1 on cycle 4.
- Valid load: load 12:34 → h1..m0 = 1,2,3,4 and s=00 next cycle; 240 cycles later time reads 12:35:00 with min_roll pulse.
- Day rollover: load 23:59, advance 59 s, then 1 more tick → 00:00:00; sec_tick, min_roll and day_roll all high in the same single cycle.
- Invalid loads: set 24:00, then 19:60, then 2:A → load_err pulses each time; displayed time unchanged; prescaler phase unchanged.
- run gating and priority:
  - run=0 for 10 cycles mid-count → digits and prescaler frozen; counting resumes from the same phase.
  - load asserted on the terminal-count cycle → loaded value shown, no sec_tick.
- Async reset mid-operation: reset asserted between clock edges at time 09:59:58 → outputs read 0 before the next edge.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared watch-controller definitions: BCD digit type, per-digit limits and
// the time-of-day validity rule used by the setting, keeping and display stages.
package watch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX         = 4'd5;
    localparam bcd_t UNITS_MAX            = 4'd9;
    localparam bcd_t HOUR_TENS_MAX        = 4'd2;
    localparam bcd_t HOUR_UNITS_MAX_AT_20 = 4'd3;

    // Minute tens share the seconds-tens limit of 5.
    function automatic logic isValidTime(input bcd_t h1, input bcd_t h0,
                                         input bcd_t m1, input bcd_t m0);
        return (h1 <= HOUR_TENS_MAX)
            && ((h1 != HOUR_TENS_MAX) || (h0 <= HOUR_UNITS_MAX_AT_20))
            && (h0 <= UNITS_MAX)
            && (m1 <= SEC_TENS_MAX)
            && (m0 <= UNITS_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit that wraps at MAX, with synchronous load/clear and a carry
// that is asserted in the cycle the digit wraps.
module bcd_digit_counter
    import watch_pkg::*;
#(
    parameter bcd_t MAX = UNITS_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    input  logic load,
    input  bcd_t loadValue,
    output bcd_t value,
    output logic carry
);

    logic atMax;

    assign atMax = (value == MAX);
    assign carry = inc && atMax;

    // Load wins over clear, clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= loadValue;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= atMax ? '0 : value + 4'd1;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// 24-hour running time-of-day: prescales clk into seconds, ripples carries
// through six BCD digits and accepts validated HH:MM loads.
module time_keeper
    import watch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  bcd_t set_h1,
    input  bcd_t set_h0,
    input  bcd_t set_m1,
    input  bcd_t set_m0,
    input  logic run,
    output bcd_t h1,
    output bcd_t h0,
    output bcd_t m1,
    output bcd_t m0,
    output bcd_t s1,
    output bcd_t s0,
    output logic sec_tick,
    output logic min_roll,
    output logic day_roll,
    output logic load_err
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] prescaler;
    logic loadValid, loadOk, loadBad, counting, advance;
    logic s0Carry, s1Carry, m0Carry, m1Carry, h0Carry, h1Carry;
    logic dayWrap, hourClr;

    assign loadValid = isValidTime(set_h1, set_h0, set_m1, set_m0);
    assign loadOk    = load && loadValid;
    assign loadBad   = load && !loadValid;
    assign counting  = run && !load;
    assign advance   = counting && (prescaler == LAST_TICK);

    // Any load, valid or not, discards the advance; only a valid one rephases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (loadOk) begin
            prescaler <= '0;
        end else if (counting) begin
            prescaler <= advance ? '0 : prescaler + PW'(1);
        end
    end

    // 23:59:59 wraps both hour digits; the hour-tens carry can only fire from
    // an out-of-range hour and is folded in so it too lands on 00.
    assign dayWrap = m1Carry && (h1 == HOUR_TENS_MAX) && (h0 == HOUR_UNITS_MAX_AT_20);
    assign hourClr = dayWrap || h1Carry;

    bcd_digit_counter #(.MAX(UNITS_MAX)) secUnits (
        .clk(clk), .reset(reset), .inc(advance), .clr(loadOk), .load(1'b0),
        .loadValue('0), .value(s0), .carry(s0Carry)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) secTens (
        .clk(clk), .reset(reset), .inc(s0Carry), .clr(loadOk), .load(1'b0),
        .loadValue('0), .value(s1), .carry(s1Carry)
    );

    bcd_digit_counter #(.MAX(UNITS_MAX)) minUnits (
        .clk(clk), .reset(reset), .inc(s1Carry), .clr(1'b0), .load(loadOk),
        .loadValue(set_m0), .value(m0), .carry(m0Carry)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) minTens (
        .clk(clk), .reset(reset), .inc(m0Carry), .clr(1'b0), .load(loadOk),
        .loadValue(set_m1), .value(m1), .carry(m1Carry)
    );

    bcd_digit_counter #(.MAX(UNITS_MAX)) hourUnits (
        .clk(clk), .reset(reset), .inc(m1Carry), .clr(hourClr), .load(loadOk),
        .loadValue(set_h0), .value(h0), .carry(h0Carry)
    );

    bcd_digit_counter #(.MAX(HOUR_TENS_MAX)) hourTens (
        .clk(clk), .reset(reset), .inc(h0Carry), .clr(hourClr), .load(loadOk),
        .loadValue(set_h1), .value(h1), .carry(h1Carry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_tick <= 1'b0;
            min_roll <= 1'b0;
            day_roll <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_tick <= advance;
            min_roll <= s1Carry;
            day_roll <= dayWrap;
            load_err <= loadBad;
        end
    end

endmodule
